// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and defaults for the LFSR sequencing controller.
package lfsr_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } ctrl_state_t;

  localparam logic [7:0] DEFAULT_SEED = 8'h01;

endpackage

// File: rtl/tick_div.sv
// Free-running step divider: one tick every 2^DIVBITS clocks plus a blink phase.
module tick_div #(
  parameter int DIVBITS = 23
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic tick_phase
);

  logic [DIVBITS-1:0] count_r;

  // wrapping divider counter
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + DIVBITS'(1);
    end
  end

  assign tick       = &count_r;
  assign tick_phase = count_r[DIVBITS-1];

endmodule

// File: rtl/lfsr_ctrl.sv
// LFSR sequencer: seed load, tick/manual stepping, period measurement and
// all-zero lockup detection, restarted on every DIP tap change.
module lfsr_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DIVBITS = 23,
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] taps,
  input  logic             run,
  input  logic             step_req,
  input  logic [WIDTH-1:0] lfsr_state,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_step,
  output logic [WIDTH:0]   period,
  output logic             period_valid,
  output logic             lockup,
  output logic             tick_phase
);

  localparam logic [WIDTH:0] MAX_CNT = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] ONE_CNT = {{WIDTH{1'b0}}, 1'b1};

  ctrl_state_t      state_r, state_s;
  logic [WIDTH-1:0] taps_q_r;
  logic             step_pend_r, step_pend_s;
  logic [WIDTH:0]   step_cnt_r, step_cnt_s, cnt_inc_s;
  logic [WIDTH:0]   period_r, period_s;
  logic             period_valid_r, period_valid_s;
  logic             lockup_r, lockup_s;
  logic             tick_s, tap_change_s, step_s, load_s;

  tick_div #(.DIVBITS(DIVBITS)) u_tick_div (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick_s),
    .tick_phase (tick_phase)
  );

  assign tap_change_s = (taps != taps_q_r);
  assign cnt_inc_s    = (step_cnt_r == MAX_CNT) ? step_cnt_r : step_cnt_r + ONE_CNT;

  // next-state and Mealy strobes; a tap change pre-empts everything else
  always_comb begin
    state_s        = state_r;
    step_pend_s    = step_pend_r | step_req;
    step_cnt_s     = step_cnt_r;
    period_s       = period_r;
    period_valid_s = period_valid_r;
    lockup_s       = lockup_r;
    step_s         = 1'b0;
    load_s         = 1'b0;
    if (tap_change_s) begin
      state_s        = LOAD;
      step_pend_s    = 1'b0;
      period_valid_s = 1'b0;
      lockup_s       = 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          load_s     = 1'b1;
          step_cnt_s = '0;
          state_s    = RUN;
        end
        RUN: begin
          if (run && tick_s) begin
            step_s     = 1'b1;
            step_cnt_s = cnt_inc_s;
            state_s    = CHECK;
          end else if (!run && (step_pend_r || step_req)) begin
            step_s      = 1'b1;
            step_pend_s = 1'b0;
            step_cnt_s  = cnt_inc_s;
            state_s     = CHECK;
          end else begin
            state_s = RUN;
          end
        end
        CHECK: begin
          if (lfsr_state == '0) begin
            lockup_s    = 1'b1;
            step_pend_s = 1'b0;
            state_s     = LOAD;
          end else begin
            state_s = RUN;
            if (!period_valid_r && (lfsr_state == SEED)) begin
              period_s       = step_cnt_r;
              period_valid_s = 1'b1;
            end else if (!period_valid_r && (step_cnt_r == MAX_CNT)) begin
              period_s       = '0;
              period_valid_s = 1'b1;
            end else begin
              period_valid_s = period_valid_r;
            end
          end
        end
        default: begin
          state_s = LOAD;
        end
      endcase
    end
  end

  // controller state and measurement registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= LOAD;
      taps_q_r       <= taps;
      step_pend_r    <= 1'b0;
      step_cnt_r     <= '0;
      period_r       <= '0;
      period_valid_r <= 1'b0;
      lockup_r       <= 1'b0;
    end else begin
      state_r        <= state_s;
      taps_q_r       <= taps;
      step_pend_r    <= step_pend_s;
      step_cnt_r     <= step_cnt_s;
      period_r       <= period_s;
      period_valid_r <= period_valid_s;
      lockup_r       <= lockup_s;
    end
  end

  assign lfsr_load    = load_s & ~rst;
  assign lfsr_step    = step_s & ~rst;
  assign lfsr_seed    = SEED;
  assign period       = period_r;
  assign period_valid = period_valid_r;
  assign lockup       = lockup_r;

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Scoreboard bench for lfsr_ctrl with a Fibonacci LFSR stand-in and a
// brute-force period/lockup reference model.
module tb_lfsr_ctrl;

  localparam logic [7:0] SEED = 8'h01;

  typedef struct {
    bit is_lock;
    int steps;
    int period;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b1;
  logic       step_req = 1'b0;
  logic [7:0] taps = 8'h80;
  logic [7:0] lfsr_q = 8'h00;
  logic       lfsr_load, lfsr_step, period_valid, lockup, tick_phase;
  logic [7:0] lfsr_seed;
  logic [8:0] period;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   total_steps = 0;
  int   steps_since_load = 0;
  int   last_step_cyc = -1;
  bit   chk_spacing = 1'b0;
  logic pv_d = 1'b0;
  logic lk_d = 1'b0;
  exp_t mon_e;
  exp_t sb_q[$];

  lfsr_ctrl #(.WIDTH(8), .DIVBITS(2), .SEED(SEED)) dut (
    .clk          (clk),
    .rst          (rst),
    .taps         (taps),
    .run          (run),
    .step_req     (step_req),
    .lfsr_state   (lfsr_q),
    .lfsr_load    (lfsr_load),
    .lfsr_seed    (lfsr_seed),
    .lfsr_step    (lfsr_step),
    .period       (period),
    .period_valid (period_valid),
    .lockup       (lockup),
    .tick_phase   (tick_phase)
  );

  always #5 clk = ~clk;

  // stand-in for the board LFSR register
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lfsr_load) lfsr_q <= lfsr_seed;
    else if (lfsr_step) lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & taps)};
  end

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Walk the sequence from SEED: first zero is lockup, first SEED is the period.
  function automatic exp_t ref_outcome(input logic [7:0] t);
    exp_t e;
    logic [7:0] s;
    s = SEED;
    e.is_lock = 1'b0;
    e.steps = 256;
    e.period = 0;
    for (int k = 1; k <= 256; k++) begin
      s = {s[6:0], ^(s & t)};
      if (s == 8'h00) begin
        e.is_lock = 1'b1;
        e.steps = k;
        return e;
      end
      if (s == SEED) begin
        e.steps = k;
        e.period = k;
        return e;
      end
    end
    return e;
  endfunction

  // monitor: pops the scoreboard on every period_valid / lockup rise
  always @(negedge clk) begin
    if (rst) begin
      pv_d = 1'b0;
      lk_d = 1'b0;
      steps_since_load = 0;
      last_step_cyc = -1;
    end else begin
      if ((period_valid && !pv_d) || (lockup && !lk_d)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("event_is_lockup", int'(lockup && !lk_d), int'(mon_e.is_lock));
          check("event_step_no", steps_since_load, mon_e.steps);
          if (mon_e.is_lock) check("reseed_after_lockup", int'(lfsr_load), 1);
          else check("period_value", int'(period), mon_e.period);
        end
      end
      pv_d = period_valid;
      lk_d = lockup;
      if (lfsr_load) begin
        steps_since_load = 0;
        last_step_cyc = -1;
      end
      if (lfsr_step) begin
        if (chk_spacing && last_step_cyc >= 0) check("step_spacing", cyc - last_step_cyc, 4);
        last_step_cyc = cyc;
        steps_since_load++;
        total_steps++;
      end
    end
  end

  // Called and returns at posedge+1. Tap change in cycle A, LOAD in cycle B.
  task automatic change_taps(input logic [7:0] t, input bit req_a, input bit req_b);
    taps = t;
    step_req = req_a;
    @(negedge clk);
    check("tapchg_no_step", int'(lfsr_step), 0);
    check("tapchg_no_load_yet", int'(lfsr_load), 0);
    @(posedge clk); #1;
    step_req = req_b;
    @(negedge clk);
    check("tapchg_load", int'(lfsr_load), 1);
    check("tapchg_pv_drop", int'(period_valid), 0);
    check("tapchg_lockup_clr", int'(lockup), 0);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({nm, "_drained"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s0, found, ph_prev;
    logic [7:0] t;
    exp_t e;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_load", int'(lfsr_load), 0);
    check("rst_step", int'(lfsr_step), 0);
    check("rst_period", int'(period), 0);
    check("rst_pv", int'(period_valid), 0);
    check("rst_lockup", int'(lockup), 0);
    check("rst_phase", int'(tick_phase), 0);
    check("rst_seed", int'(lfsr_seed), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_spacing = 1'b1;
    sb_q.push_back(ref_outcome(8'h80));
    @(negedge clk);
    check("load_after_reset", int'(lfsr_load), 1);
    @(posedge clk); #1;
    drain("t80_period", 200);
    check("t80_period_is_8", int'(period), 8);
    check("t80_pv", int'(period_valid), 1);
    check("t80_no_lockup", int'(lockup), 0);

    // three more steps, then mid-run change to C0
    s0 = total_steps;
    for (int i = 0; i < 60 && total_steps < s0 + 3; i++) @(posedge clk);
    #1;
    check("three_more_steps", total_steps - s0, 3);
    sb_q.push_back(ref_outcome(8'hC0));
    change_taps(8'hC0, 1'b0, 1'b0);
    drain("tC0_period", 1400);

    // all-zero taps: lockup at step 8 with auto-reseed, never valid
    sb_q.push_back(ref_outcome(8'h00));
    change_taps(8'h00, 1'b0, 1'b0);
    drain("t00_lockup", 200);
    idle(40);
    @(negedge clk);
    check("t00_lockup_sticky", int'(lockup), 1);
    check("t00_pv_stays_0", int'(period_valid), 0);
    @(posedge clk); #1;

    // paused: pulses in LOAD and RUN collapse into one step; ticks ignored
    chk_spacing = 1'b0;
    run = 1'b0;
    change_taps(8'h80, 1'b0, 1'b1);
    s0 = total_steps;
    @(negedge clk);
    check("manual_step_now", int'(lfsr_step), 1);
    @(posedge clk); #1;
    step_req = 1'b0;
    idle(12);
    check("collapsed_one_step", total_steps - s0, 1);
    // pulse in RUN steps at once; pulse in CHECK is held for the next RUN
    step_req = 1'b1;
    @(negedge clk);
    check("req_in_run_steps", int'(lfsr_step), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("req_in_check_waits", int'(lfsr_step), 0);
    @(posedge clk); #1;
    step_req = 1'b0;
    @(negedge clk);
    check("held_req_steps", int'(lfsr_step), 1);
    @(posedge clk); #1;
    idle(10);
    check("paused_total_steps", total_steps - s0, 3);

    // tap change coinciding with tick and step_req
    found = 0;
    ph_prev = 1;
    for (int i = 0; i < 16 && found == 0; i++) begin
      @(negedge clk);
      if (ph_prev == 0 && tick_phase == 1'b1) found = 1;
      ph_prev = int'(tick_phase);
    end
    check("tick_phase_found", found, 1);
    @(posedge clk); #1;
    run = 1'b1;
    change_taps(8'hC0, 1'b1, 1'b0);
    run = 1'b0;
    s0 = total_steps;
    idle(16);
    check("pend_cleared_by_load", total_steps - s0, 0);

    // taps that never return to SEED: period 0 at step 256
    chk_spacing = 1'b1;
    run = 1'b1;
    found = 0;
    t = 8'h00;
    for (int k = 0; k < 256 && found == 0; k++) begin
      e = ref_outcome(8'(k));
      if (!e.is_lock && e.period == 0) begin
        found = 1;
        t = 8'(k);
      end
    end
    check("no_return_taps_found", found, 1);
    sb_q.push_back(ref_outcome(t));
    change_taps(t, 1'b0, 1'b0);
    drain("no_return", 1400);
    check("no_return_period_0", int'(period), 0);
    check("no_return_pv", int'(period_valid), 1);

    // random tap settings
    for (int r = 0; r < 6; r++) begin
      t = 8'($urandom_range(0, 255));
      if (t == taps) t = t ^ 8'h01;
      sb_q.push_back(ref_outcome(t));
      change_taps(t, 1'b0, 1'b0);
      drain("random", 1400);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", fails);
    $fatal(1, "watchdog");
  end

endmodule
